// File: rtl/mem_access_stage.sv
// MEM stage: resolves branches, issues loads/stores over a request/ready port,
// aligns and extends load data, and registers the MEM/WB outputs.
module mem_access_stage #(
    parameter int Width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [Width-1:0]   branch_addr,
    input  logic [Width-1:0]   alu_result,
    input  logic [Width-1:0]   rs2_data,
    input  logic               zero,
    input  logic               branch,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         funct3,
    input  logic [2:0]         wb_ctrl_in,
    input  logic [4:0]         rd_in,
    output logic               stall,
    output logic               pc_sel,
    output logic [Width-1:0]   branch_target,
    output logic               mem_req,
    output logic               mem_we,
    output logic [Width-1:0]   mem_addr,
    output logic [Width/8-1:0] mem_be,
    output logic [Width-1:0]   mem_wdata,
    input  logic [Width-1:0]   mem_rdata,
    input  logic               mem_ready,
    output logic               wb_valid,
    output logic               wb_misalign,
    output logic [Width-1:0]   wb_alu_result,
    output logic [Width-1:0]   wb_load_data,
    output logic [2:0]         wb_ctrl,
    output logic [4:0]         wb_rd
);
    localparam int BEW  = Width / 8;
    localparam int OFFW = $clog2(BEW);
    localparam logic [BEW-1:0] BE_B = BEW'(1'b1);
    localparam logic [BEW-1:0] BE_H = BEW'(2'b11);
    localparam logic [BEW-1:0] BE_W = BEW'(4'hF);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t           state_q;
    logic [OFFW-1:0]  off_q;
    logic [2:0]       funct3_q;
    logic [2:0]       pend_ctrl_q;
    logic [4:0]       pend_rd_q;
    logic [Width-1:0] pend_alu_q;

    logic [OFFW-1:0]  off_s;
    logic             access_s;
    logic             misalign_s;
    logic             go_s;
    logic [BEW-1:0]   be_s;
    logic [Width-1:0] wdata_s;
    logic [Width-1:0] lane_s;
    logic [Width-1:0] load_s;

    assign off_s         = alu_result[OFFW-1:0];
    assign access_s      = in_valid & (mem_read | mem_write);
    assign go_s          = access_s & ~misalign_s;
    assign branch_target = branch_addr;
    assign pc_sel        = in_valid & branch & zero & (state_q == IDLE) & ~rst;
    assign stall         = ((state_q == IDLE) & go_s) | ((state_q == REQ) & ~mem_ready);

    // Access size decode: alignment check, byte enables and lane-replicated store data
    always_comb begin
        misalign_s = 1'b1;
        be_s       = {BEW{1'b0}};
        wdata_s    = {Width{1'b0}};
        case (funct3)
            3'b000, 3'b100: begin
                misalign_s = 1'b0;
                be_s       = BE_B << off_s;
                wdata_s    = {BEW{rs2_data[7:0]}};
            end
            3'b001, 3'b101: begin
                misalign_s = off_s[0];
                be_s       = BE_H << off_s;
                wdata_s    = {(Width/16){rs2_data[15:0]}};
            end
            3'b010, 3'b110: begin
                // The unsigned word form only exists on the 64-bit datapath
                misalign_s = ((funct3[2] == 1'b1) && (Width == 32)) || (off_s[1:0] != 2'b00);
                be_s       = BE_W << off_s;
                wdata_s    = {(Width/32){rs2_data[31:0]}};
            end
            3'b011: begin
                misalign_s = (Width == 32) || (off_s != {OFFW{1'b0}});
                be_s       = {BEW{1'b1}};
                wdata_s    = rs2_data;
            end
            default: begin
                misalign_s = 1'b1;
                be_s       = {BEW{1'b0}};
                wdata_s    = {Width{1'b0}};
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the latched offset
    always_comb begin
        lane_s = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_s = Width'($signed(lane_s[7:0]));
            3'b100:  load_s = Width'(lane_s[7:0]);
            3'b001:  load_s = Width'($signed(lane_s[15:0]));
            3'b101:  load_s = Width'(lane_s[15:0]);
            3'b010:  load_s = Width'($signed(lane_s[31:0]));
            3'b110:  load_s = Width'(lane_s[31:0]);
            default: load_s = lane_s;
        endcase
    end

    // Stage FSM with registered memory-port and MEM/WB outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            off_q         <= {OFFW{1'b0}};
            funct3_q      <= 3'b000;
            pend_ctrl_q   <= 3'b000;
            pend_rd_q     <= 5'd0;
            pend_alu_q    <= {Width{1'b0}};
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= {Width{1'b0}};
            mem_be        <= {BEW{1'b0}};
            mem_wdata     <= {Width{1'b0}};
            wb_valid      <= 1'b0;
            wb_misalign   <= 1'b0;
            wb_alu_result <= {Width{1'b0}};
            wb_load_data  <= {Width{1'b0}};
            wb_ctrl       <= 3'b000;
            wb_rd         <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_s) begin
                        state_q     <= REQ;
                        off_q       <= off_s;
                        funct3_q    <= funct3;
                        pend_ctrl_q <= wb_ctrl_in;
                        pend_rd_q   <= rd_in;
                        pend_alu_q  <= alu_result;
                        mem_req     <= 1'b1;
                        mem_we      <= mem_write;
                        mem_addr    <= {alu_result[Width-1:OFFW], {OFFW{1'b0}}};
                        mem_be      <= be_s;
                        mem_wdata   <= wdata_s;
                        wb_valid    <= 1'b0;
                    end else if (in_valid) begin
                        wb_valid      <= 1'b1;
                        wb_misalign   <= access_s & misalign_s;
                        wb_alu_result <= alu_result;
                        wb_load_data  <= {Width{1'b0}};
                        wb_ctrl       <= wb_ctrl_in;
                        wb_rd         <= rd_in;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state_q       <= IDLE;
                        mem_req       <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_misalign   <= 1'b0;
                        wb_alu_result <= pend_alu_q;
                        wb_load_data  <= mem_we ? {Width{1'b0}} : load_s;
                        wb_ctrl       <= pend_ctrl_q;
                        wb_rd         <= pend_rd_q;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule
